ws2812b_frame_sched: RTL and testbench

Refresh scheduler for the WS2812B LED chain.
- Periodically scans the pixel frame buffer written by the game logic and serialises each 24-bit GRB word, MSB first, into the HL bit encoder over a valid/ready handshake.
- Inserts the 300 us latch/reset gap after the last pixel.
- Sits between the game/data-control logic (frame buffer owner) and the HL encoder that drives data_pwm.

---
 rtl/ws2812b_frame_sched_if.sv | 22 ++
 rtl/ws2812b_frame_sched.sv | 126 ++++++++++++
 tb/tb_ws2812b_frame_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_frame_sched_if.sv
// Frame-buffer read port and serial bit stream between the WS2812B refresh
// scheduler (master) and the frame buffer / HL encoder pair (slave).
interface ws2812b_frame_sched_if #(
  parameter int ADDR_W = 6
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              bit_valid;
  logic              bit_data;
  logic              bit_ready;

  modport master (
    output rd_en, rd_addr, bit_valid, bit_data,
    input  rd_data, bit_ready
  );

  modport slave (
    input  rd_en, rd_addr, bit_valid, bit_data,
    output rd_data, bit_ready
  );
endinterface

// File: rtl/ws2812b_frame_sched.sv
// WS2812B refresh scheduler: periodic frame scan, GRB serialisation, latch gap.
// Optional BRIGHT_SCALE_EN adds i_bright, a per-byte right shift applied on load.
module ws2812b_frame_sched #(
  parameter int LED_NUM      = 64,
  parameter int ADDR_W       = 6,
  parameter int T_RESET      = 15000,
  parameter int FRAME_PERIOD = 1000000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_en,
`ifdef BRIGHT_SCALE_EN
  input  logic [1:0]            i_bright,
`endif
  ws2812b_frame_sched_if.master io_led,
  output logic                  o_rst_gap,
  output logic                  o_buf_lock,
  output logic                  o_frame_done,
  output logic                  o_overrun
);

  localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int GW = $clog2(T_RESET + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t            r_state, w_next;
  logic [TW-1:0]     r_timer;
  logic [ADDR_W-1:0] r_pix;
  logic [4:0]        r_bitcnt;
  logic [GW-1:0]     r_gap;
  logic [23:0]       r_shreg;

  logic              w_tick, w_acc, w_last_bit, w_last_pix, w_gap_end;
  logic [23:0]       w_load;

  assign w_tick     = i_en && (r_timer == TW'(FRAME_PERIOD - 1));
  assign w_acc      = (r_state == S_SHIFT) && io_led.bit_ready;
  assign w_last_bit = (r_bitcnt == 5'd23);
  assign w_last_pix = (r_pix == ADDR_W'(LED_NUM - 1));
  assign w_gap_end  = (r_gap == GW'(T_RESET));

`ifdef BRIGHT_SCALE_EN
  assign w_load = {io_led.rd_data[23:16] >> i_bright,
                   io_led.rd_data[15:8]  >> i_bright,
                   io_led.rd_data[7:0]   >> i_bright};
`else
  assign w_load = io_led.rd_data;
`endif

  // Timer keeps running during a frame so the refresh cadence is not stretched.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n || !i_en)                   r_timer <= '0;
    else if (r_timer == TW'(FRAME_PERIOD - 1))   r_timer <= '0;
    else                                         r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_pix    <= '0;
      r_bitcnt <= '0;
      r_gap    <= '0;
      r_shreg  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pix <= '0;
          r_gap <= '0;
        end
        S_LOAD: begin
          r_shreg  <= w_load;
          r_bitcnt <= '0;
        end
        S_SHIFT: if (w_acc) begin
          r_shreg  <= {r_shreg[22:0], 1'b0};
          r_bitcnt <= r_bitcnt + 5'd1;
          if (w_last_bit && !w_last_pix) r_pix <= r_pix + 1'b1;
        end
        S_GAP: r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_acc && w_last_bit) w_next = w_last_pix ? S_GAP : S_FETCH;
      S_GAP:   if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The frame_done cycle is the tail of GAP, so buf_lock still covers it.
  always_comb begin
    io_led.rd_en     = 1'b0;
    io_led.rd_addr   = r_pix;
    io_led.bit_valid = 1'b0;
    io_led.bit_data  = 1'b0;
    o_rst_gap        = 1'b0;
    o_frame_done     = 1'b0;
    o_buf_lock       = (r_state != S_IDLE);
    o_overrun        = w_tick && (r_state != S_IDLE);
    case (r_state)
      S_FETCH: io_led.rd_en = 1'b1;
      S_SHIFT: begin
        io_led.bit_valid = 1'b1;
        io_led.bit_data  = r_shreg[23];
      end
      S_GAP: begin
        o_rst_gap    = (r_gap < GW'(T_RESET));
        o_frame_done = w_gap_end;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_frame_sched.sv
// Bench for ws2812b_frame_sched: table of frame scenarios checked against a
// bit scoreboard, plus overrun (short period) and mid-frame reset sequences.
module tb_ws2812b_frame_sched;
  localparam int LED_NUM = 4;
  localparam int ADDR_W  = 6;
  localparam int T_RESET = 15;
  localparam int FP      = 400;
  localparam int FP2     = 50;
  localparam int NBITS   = 24 * LED_NUM;

  typedef struct {
    string       name;
    int          ready_div;
    int          drop_pix;
    int          bright;
    logic [23:0] pix0;
    logic [23:0] word0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst2_n = 1'b0, en = 1'b0, en2 = 1'b0;
  logic rst_gap, buf_lock, frame_done, overrun;
  logic rst_gap2, buf_lock2, frame_done2, overrun2;
`ifdef BRIGHT_SCALE_EN
  logic [1:0] bright = 2'd0;
`endif
  logic [23:0] ram [LED_NUM];
  int ready_div = 1;
  int n_chk = 0, n_pass = 0;
  logic exp_q [$];
  int n_acc = 0, n_bit_err = 0, n_hold_err = 0, n_gap = 0, n_done = 0;
  int n_ovr = 0, n_rd = 0, n_addr_err = 0, n_lock_err = 0;

  ws2812b_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();
  ws2812b_frame_sched_if #(.ADDR_W(ADDR_W)) bus2 ();

  ws2812b_frame_sched #(.LED_NUM(LED_NUM), .ADDR_W(ADDR_W), .T_RESET(T_RESET),
                        .FRAME_PERIOD(FP)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_en(en),
`ifdef BRIGHT_SCALE_EN
    .i_bright(bright),
`endif
    .io_led(bus), .o_rst_gap(rst_gap), .o_buf_lock(buf_lock),
    .o_frame_done(frame_done), .o_overrun(overrun));

  ws2812b_frame_sched #(.LED_NUM(LED_NUM), .ADDR_W(ADDR_W), .T_RESET(T_RESET),
                        .FRAME_PERIOD(FP2)) dut50 (
    .i_sys_clk(clk), .i_sys_rst_n(rst2_n), .i_en(en2),
`ifdef BRIGHT_SCALE_EN
    .i_bright(2'd0),
`endif
    .io_led(bus2), .o_rst_gap(rst_gap2), .o_buf_lock(buf_lock2),
    .o_frame_done(frame_done2), .o_overrun(overrun2));

  always #5 clk = ~clk;

  // Frame buffer: registered read, data valid the cycle after rd_en.
  always @(posedge clk) if (bus.rd_en)  bus.rd_data  <= ram[bus.rd_addr[1:0]];
  always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= ram[bus2.rd_addr[1:0]];

  function automatic logic [23:0] model(input logic [23:0] p, input int b);
    logic [7:0] g, r, bl;
    g  = p[23:16] >> b;
    r  = p[15:8]  >> b;
    bl = p[7:0]   >> b;
    return {g, r, bl};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  initial begin
    int cyc;
    cyc = 0;
    bus.bit_ready  = 1'b0;
    bus2.bit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.bit_ready = (ready_div <= 1) || (cyc % 3 == 0);
    end
  end

  // Monitor on the main DUT: scoreboard pops, stall stability, lock/addr model.
  initial begin
    logic prev_stall, prev_bit, in_fr, exp_lock, b;
    logic [ADDR_W-1:0] exp_addr;
    prev_stall = 1'b0; prev_bit = 1'b0; in_fr = 1'b0; exp_addr = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && !(bus.bit_valid && bus.bit_data == prev_bit)) n_hold_err++;
      prev_stall = bus.bit_valid && !bus.bit_ready;
      prev_bit   = bus.bit_data;
      if (bus.bit_valid && bus.bit_ready) begin
        n_acc++;
        if (exp_q.size() == 0) n_bit_err++;
        else begin
          b = exp_q.pop_front();
          if (b !== bus.bit_data) n_bit_err++;
        end
      end
      if (rst_gap)    n_gap++;
      if (frame_done) n_done++;
      if (overrun)    n_ovr++;
      exp_lock = in_fr || bus.rd_en;
      if (buf_lock !== exp_lock) n_lock_err++;
      if (bus.rd_en) begin
        n_rd++;
        if (bus.rd_addr !== exp_addr) n_addr_err++;
        exp_addr = (exp_addr == ADDR_W'(LED_NUM - 1)) ? '0 : exp_addr + 1'b1;
        in_fr = 1'b1;
      end
      if (frame_done) in_fr = 1'b0;
    end
  end

  initial begin
    vec_t tv [$];
    string nm;
    int k, nw, b_acc, b_bit, b_hold, b_gap, b_done, b_ovr, b_rd, b_addr, b_lock;
    int ovr, rds, dones, acc2, aerr, ovr_idle;
    logic [23:0] w0, wexp;
    logic [ADDR_W-1:0] ea;

    for (int i = 0; i < LED_NUM; i++) ram[i] = 24'hA50F00 + 24'(i);
    tv.push_back('{"ready_all",   1, -1, 0, 24'hA50F00, 24'hA50F00});
    tv.push_back('{"ready_1in3",  3, -1, 0, 24'hA50F00, 24'hA50F00});
    tv.push_back('{"en_drop_px1", 1,  1, 0, 24'hA50F00, 24'hA50F00});
`ifdef BRIGHT_SCALE_EN
    tv.push_back('{"bright2",     1, -1, 2, 24'hFF8040, 24'h3F2010});
`endif

    for (int v = 0; v < tv.size(); v++) begin
      nm = tv[v].name;
      ready_div = tv[v].ready_div;
`ifdef BRIGHT_SCALE_EN
      bright = 2'(tv[v].bright);
`endif
      ram[0] = tv[v].pix0;
      en = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk({nm, " reset outputs"}, {bus.rd_en, |bus.rd_addr, bus.bit_valid, bus.bit_data,
                                  rst_gap, buf_lock, frame_done, overrun}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < LED_NUM; i++) begin
        wexp = model(ram[i], tv[v].bright);
        for (int j = 23; j >= 0; j--) exp_q.push_back(wexp[j]);
      end
      b_acc = n_acc; b_bit = n_bit_err; b_hold = n_hold_err; b_gap = n_gap;
      b_done = n_done; b_ovr = n_ovr; b_rd = n_rd; b_addr = n_addr_err; b_lock = n_lock_err;

      en = 1'b1; k = 1;
      do begin @(negedge clk); k++; end while (!bus.rd_en && k < 2000);
      chk({nm, " first rd_en cycle"}, k, FP + 1);

      k = 0; nw = 0; w0 = '0;
      while (!frame_done && k < 5000) begin
        @(negedge clk); k++;
        if (bus.bit_valid && bus.bit_ready && nw < 24) begin
          w0 = {w0[22:0], bus.bit_data}; nw++;
        end
        if (tv[v].drop_pix >= 0 && bus.rd_en && bus.rd_addr == ADDR_W'(tv[v].drop_pix))
          en = 1'b0;
      end
      chk({nm, " frame_done seen"}, frame_done, 1);
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk({nm, " bits accepted"}, n_acc - b_acc, NBITS);
      chk({nm, " bit errors"}, n_bit_err - b_bit, 0);
      chk({nm, " stall hold errors"}, n_hold_err - b_hold, 0);
      chk({nm, " first serial word"}, w0, tv[v].word0);
      chk({nm, " rst_gap cycles"}, n_gap - b_gap, T_RESET);
      chk({nm, " frame_done pulses"}, n_done - b_done, 1);
      chk({nm, " rd_en count"}, n_rd - b_rd, LED_NUM);
      chk({nm, " rd_addr order errors"}, n_addr_err - b_addr, 0);
      chk({nm, " buf_lock errors"}, n_lock_err - b_lock, 0);
      chk({nm, " overrun pulses"}, n_ovr - b_ovr, 0);
      chk({nm, " leftover expected bits"}, exp_q.size(), 0);
      if (tv[v].drop_pix >= 0) begin
        b_rd = n_rd;
        repeat (1000) @(negedge clk);
        chk({nm, " rd_en after en drop"}, n_rd - b_rd, 0);
      end
    end

    // Short refresh period: ticks landing mid-frame must be dropped, not queued.
    ready_div = 1;
    rst2_n = 1'b0; en2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("fp50 reset outputs", {bus2.rd_en, bus2.bit_valid, rst_gap2, buf_lock2,
                               frame_done2, overrun2}, 0);
    rst2_n = 1'b1; en2 = 1'b1;
    ovr = 0; rds = 0; dones = 0; acc2 = 0; aerr = 0; ovr_idle = 0; ea = '0; k = 0;
    while (dones < 3 && k < 2000) begin
      @(negedge clk); k++;
      if (overrun2) begin
        ovr++;
        if (!buf_lock2) ovr_idle++;
      end
      if (bus2.bit_valid && bus2.bit_ready) acc2++;
      if (bus2.rd_en) begin
        rds++;
        if (bus2.rd_addr != ea) aerr++;
        ea = (ea == ADDR_W'(LED_NUM - 1)) ? '0 : ea + 1'b1;
      end
      if (frame_done2) dones++;
    end
    en2 = 1'b0;
    chk("fp50 frames completed", dones, 3);
    chk("fp50 overrun pulses", ovr, 6);
    chk("fp50 overrun while idle", ovr_idle, 0);
    chk("fp50 rd_en count", rds, 3 * LED_NUM);
    chk("fp50 pixel order errors", aerr, 0);
    chk("fp50 bits accepted", acc2, 3 * NBITS);

    // One-cycle reset in the middle of SHIFT.
    ram[0] = 24'hA50F00;
`ifdef BRIGHT_SCALE_EN
    bright = 2'd0;
`endif
    en = 1'b1; k = 0;
    while (!bus.bit_valid && k < 1000) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk("midreset in shift", bus.bit_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset outputs cleared", {bus.rd_en, |bus.rd_addr, bus.bit_valid, bus.bit_data,
                                     rst_gap, buf_lock, frame_done, overrun}, 0);
    rst_n = 1'b1; k = 1;
    do begin @(negedge clk); k++; end while (!bus.rd_en && k < 2000);
    chk("midreset next rd_en cycle", k, FP + 1);
    chk("midreset restart rd_addr", bus.rd_addr, 0);
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
